// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - two-requester (instruction/data) memory arbiter
// One memory transaction in flight; grants round-robin or data-first on a tie.
module mem_arb #(
  parameter int unsigned RR = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ib_req_addr,
  input  logic [2:0]  ib_req_size,
  input  logic        ib_req_valid,
  output logic        ib_req_ready,
  output logic [63:0] ib_resp_rdata,
  output logic        ib_resp_valid,
  input  logic        ib_resp_ready,
  input  logic [31:0] db_req_addr,
  input  logic [63:0] db_req_wdata,
  input  logic [7:0]  db_req_wmask,
  input  logic        db_req_wen,
  input  logic [2:0]  db_req_size,
  input  logic        db_req_valid,
  output logic        db_req_ready,
  output logic [63:0] db_resp_rdata,
  output logic        db_resp_valid,
  input  logic        db_resp_ready,
  output logic [31:0] mem_req_addr,
  output logic [63:0] mem_req_wdata,
  output logic [7:0]  mem_req_wmask,
  output logic        mem_req_wen,
  output logic [2:0]  mem_req_size,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  input  logic [63:0] mem_resp_rdata,
  input  logic        mem_resp_valid,
  output logic        mem_resp_ready
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t     state;
  logic       owner_db;
  logic       last_db;
  logic [4:0] beats;
  logic       grant_any;
  logic       grant_db;
  logic       in_resp;

  // Writes always complete in one beat; reads wider than 8 bytes are split into 8-byte beats.
  function automatic logic [4:0] beats_for(input logic wen, input logic [2:0] size);
    if (wen || size <= 3'd3) return 5'd1;
    return 5'd1 << (size - 3'd3);
  endfunction

  always_comb begin
    grant_any = (state == IDLE) && !rst && (ib_req_valid || db_req_valid);
    if (ib_req_valid && db_req_valid) grant_db = (RR != 0) ? ~last_db : 1'b1;
    else                              grant_db = db_req_valid;
    ib_req_ready   = grant_any && !grant_db;
    db_req_ready   = grant_any && grant_db;
    in_resp        = (state == RESP);
    ib_resp_valid  = in_resp && !owner_db && mem_resp_valid;
    db_resp_valid  = in_resp && owner_db && mem_resp_valid;
    ib_resp_rdata  = (in_resp && !owner_db) ? mem_resp_rdata : 64'd0;
    db_resp_rdata  = (in_resp && owner_db) ? mem_resp_rdata : 64'd0;
    mem_resp_ready = in_resp && (owner_db ? db_resp_ready : ib_resp_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      owner_db      <= 1'b0;
      last_db       <= 1'b0;
      beats         <= 5'd0;
      mem_req_addr  <= 32'd0;
      mem_req_wdata <= 64'd0;
      mem_req_wmask <= 8'd0;
      mem_req_wen   <= 1'b0;
      mem_req_size  <= 3'd0;
      mem_req_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            owner_db      <= grant_db;
            last_db       <= grant_db;
            mem_req_valid <= 1'b1;
            state         <= REQ;
            if (grant_db) begin
              mem_req_addr  <= db_req_addr;
              mem_req_wdata <= db_req_wdata;
              mem_req_wmask <= db_req_wmask;
              mem_req_wen   <= db_req_wen;
              mem_req_size  <= db_req_size;
              beats         <= beats_for(db_req_wen, db_req_size);
            end else begin
              mem_req_addr  <= ib_req_addr;
              mem_req_wdata <= 64'd0;
              mem_req_wmask <= 8'd0;
              mem_req_wen   <= 1'b0;
              mem_req_size  <= ib_req_size;
              beats         <= beats_for(1'b0, ib_req_size);
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= RESP;
          end
        end
        RESP: begin
          if (mem_resp_valid && mem_resp_ready) begin
            beats <= beats - 5'd1;
            if (beats == 5'd1) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - self-checking bench for mem_arb
// Directed scenarios plus a long randomized run against a transaction-level model.
module tb_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ib_req_addr;
  logic [2:0]  ib_req_size;
  logic        ib_req_valid;
  logic        ib_resp_ready;
  logic [31:0] db_req_addr;
  logic [63:0] db_req_wdata;
  logic [7:0]  db_req_wmask;
  logic        db_req_wen;
  logic [2:0]  db_req_size;
  logic        db_req_valid;
  logic        db_resp_ready;
  logic        mem_req_ready;
  logic [63:0] mem_resp_rdata;
  logic        mem_resp_valid;

  logic        ib_req_ready, db_req_ready, ib_resp_valid, db_resp_valid;
  logic [63:0] ib_resp_rdata, db_resp_rdata, mem_req_wdata;
  logic [31:0] mem_req_addr;
  logic [7:0]  mem_req_wmask;
  logic        mem_req_wen, mem_req_valid, mem_resp_ready;
  logic [2:0]  mem_req_size;

  logic        f_ib_req_ready, f_db_req_ready, f_ib_resp_valid, f_db_resp_valid;
  logic [63:0] f_ib_resp_rdata, f_db_resp_rdata, f_mem_req_wdata;
  logic [31:0] f_mem_req_addr;
  logic [7:0]  f_mem_req_wmask;
  logic        f_mem_req_wen, f_mem_req_valid, f_mem_resp_ready;
  logic [2:0]  f_mem_req_size;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arb #(.RR(1)) u_dut (
    .clk(clk), .rst(rst),
    .ib_req_addr(ib_req_addr), .ib_req_size(ib_req_size), .ib_req_valid(ib_req_valid),
    .ib_req_ready(ib_req_ready), .ib_resp_rdata(ib_resp_rdata), .ib_resp_valid(ib_resp_valid),
    .ib_resp_ready(ib_resp_ready),
    .db_req_addr(db_req_addr), .db_req_wdata(db_req_wdata), .db_req_wmask(db_req_wmask),
    .db_req_wen(db_req_wen), .db_req_size(db_req_size), .db_req_valid(db_req_valid),
    .db_req_ready(db_req_ready), .db_resp_rdata(db_resp_rdata), .db_resp_valid(db_resp_valid),
    .db_resp_ready(db_resp_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_req_wen(mem_req_wen), .mem_req_size(mem_req_size), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_resp_rdata(mem_resp_rdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready)
  );

  mem_arb #(.RR(0)) u_fp (
    .clk(clk), .rst(rst),
    .ib_req_addr(ib_req_addr), .ib_req_size(ib_req_size), .ib_req_valid(ib_req_valid),
    .ib_req_ready(f_ib_req_ready), .ib_resp_rdata(f_ib_resp_rdata), .ib_resp_valid(f_ib_resp_valid),
    .ib_resp_ready(ib_resp_ready),
    .db_req_addr(db_req_addr), .db_req_wdata(db_req_wdata), .db_req_wmask(db_req_wmask),
    .db_req_wen(db_req_wen), .db_req_size(db_req_size), .db_req_valid(db_req_valid),
    .db_req_ready(f_db_req_ready), .db_resp_rdata(f_db_resp_rdata), .db_resp_valid(f_db_resp_valid),
    .db_resp_ready(db_resp_ready),
    .mem_req_addr(f_mem_req_addr), .mem_req_wdata(f_mem_req_wdata), .mem_req_wmask(f_mem_req_wmask),
    .mem_req_wen(f_mem_req_wen), .mem_req_size(f_mem_req_size), .mem_req_valid(f_mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_resp_rdata(mem_resp_rdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(f_mem_resp_ready)
  );

  logic [241:0] dut_out;
  assign dut_out = {ib_req_ready, db_req_ready, mem_req_valid, mem_req_addr, mem_req_wdata,
                    mem_req_wmask, mem_req_wen, mem_req_size, ib_resp_valid, mem_resp_ready,
                    db_resp_valid, ib_resp_rdata, db_resp_rdata};

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level model: one pending transaction record plus the last-winner flag.
  bit          m_busy, m_issued, m_owner_db, m_last_db;
  int          m_beats;
  logic [31:0] m_addr;
  logic [63:0] m_wdata;
  logic [7:0]  m_wmask;
  logic        m_wen;
  logic [2:0]  m_size;

  initial begin
    m_busy = 0; m_issued = 0; m_owner_db = 0; m_last_db = 0; m_beats = 0;
    m_addr = '0; m_wdata = '0; m_wmask = '0; m_wen = 1'b0; m_size = '0;
  end

  always @(negedge clk) begin
    bit g, gdb, resp, rrdy;
    logic [241:0] e;
    if (rst) begin
      m_busy = 0; m_issued = 0; m_owner_db = 0; m_last_db = 0; m_beats = 0;
      m_addr = '0; m_wdata = '0; m_wmask = '0; m_wen = 1'b0; m_size = '0;
    end else begin
      g    = !m_busy && (ib_req_valid || db_req_valid);
      gdb  = (ib_req_valid && db_req_valid) ? !m_last_db : db_req_valid;
      resp = m_busy && m_issued;
      rrdy = resp && (m_owner_db ? db_resp_ready : ib_resp_ready);
      e = {g && !gdb, g && gdb, m_busy && !m_issued, m_addr, m_wdata, m_wmask, m_wen, m_size,
           resp && !m_owner_db && mem_resp_valid, rrdy, resp && m_owner_db && mem_resp_valid,
           (resp && !m_owner_db) ? mem_resp_rdata : 64'd0,
           (resp && m_owner_db) ? mem_resp_rdata : 64'd0};
      chk("cycle", dut_out, e);
      if (g) begin
        m_busy = 1; m_issued = 0; m_owner_db = gdb; m_last_db = gdb;
        if (gdb) begin
          m_addr = db_req_addr; m_wdata = db_req_wdata; m_wmask = db_req_wmask;
          m_wen = db_req_wen; m_size = db_req_size;
        end else begin
          m_addr = ib_req_addr; m_wdata = '0; m_wmask = '0; m_wen = 1'b0; m_size = ib_req_size;
        end
        m_beats = (m_wen || m_size <= 3) ? 1 : 2 ** (int'(m_size) - 3);
      end else if (m_busy && !m_issued) begin
        if (mem_req_ready) m_issued = 1;
      end else if (resp && mem_resp_valid && rrdy) begin
        m_beats--;
        if (m_beats == 0) m_busy = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ib_req_addr = '0; ib_req_size = '0; ib_req_valid = 1'b0; ib_resp_ready = 1'b1;
    db_req_addr = '0; db_req_wdata = '0; db_req_wmask = '0; db_req_wen = 1'b0;
    db_req_size = '0; db_req_valid = 1'b0; db_resp_ready = 1'b1;
    mem_req_ready = 1'b0; mem_resp_rdata = '0; mem_resp_valid = 1'b0;
  endtask

  initial begin
    int got[$];
    int exp_g[4];
    int fp_db, fp_ib, beats, ib_seen;

    rst = 1'b1;
    idle_inputs();
    step(); step();
    @(negedge clk);
    chk("reset_outputs", dut_out, '0);

    // ib read, single beat
    step();
    rst = 1'b0;
    ib_req_valid = 1'b1; ib_req_addr = 32'h8000_0000; ib_req_size = 3'd3; mem_req_ready = 1'b1;
    @(negedge clk);
    chk("t1_ib_ready_c0", ib_req_ready, 1);
    chk("t1_db_ready_c0", db_req_ready, 0);
    chk("t1_mem_valid_c0", mem_req_valid, 0);
    step();
    ib_req_valid = 1'b0;
    @(negedge clk);
    chk("t1_mem_valid_c1", mem_req_valid, 1);
    chk("t1_addr", mem_req_addr, 32'h8000_0000);
    step();
    mem_resp_valid = 1'b1; mem_resp_rdata = 64'h1122_3344_5566_7788;
    @(negedge clk);
    chk("t1_ib_rvalid", ib_resp_valid, 1);
    chk("t1_ib_rdata", ib_resp_rdata, 64'h1122_3344_5566_7788);
    chk("t1_db_rvalid", db_resp_valid, 0);
    step();
    mem_resp_valid = 1'b0;

    // continuous contention: RR alternates from db, fixed priority starves ib
    rst = 1'b1; idle_inputs(); step();
    rst = 1'b0;
    ib_req_valid = 1'b1; ib_req_size = 3'd3; ib_req_addr = 32'h100;
    db_req_valid = 1'b1; db_req_size = 3'd3; db_req_addr = 32'h200;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1;
    exp_g = '{1, 0, 1, 0};
    fp_db = 0; fp_ib = 0;
    for (int c = 0; c < 40 && got.size() < 4; c++) begin
      @(negedge clk);
      if (db_req_ready) got.push_back(1);
      else if (ib_req_ready) got.push_back(0);
      if (f_db_req_ready) fp_db++;
      if (f_ib_req_ready) fp_ib++;
      step();
    end
    chk("t2_ngrants", got.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t2_grant%0d", i), (i < got.size()) ? got[i] : 9, exp_g[i]);
    chk("t3_fp_db", fp_db, 4);
    chk("t3_fp_ib", fp_ib, 0);

    // db 64-byte read: 8 beats with a 3-cycle requester stall
    rst = 1'b1; idle_inputs(); step();
    rst = 1'b0;
    db_req_valid = 1'b1; db_req_size = 3'd6; db_req_addr = 32'h2000; mem_req_ready = 1'b1;
    step();
    db_req_valid = 1'b0;
    step();
    mem_resp_valid = 1'b1;
    beats = 0; ib_seen = 0;
    mem_resp_rdata = 64'hA000;
    for (int c = 0; c < 40 && beats < 8; c++) begin
      db_resp_ready = !(c >= 2 && c < 5);
      @(negedge clk);
      if (!db_resp_ready) chk($sformatf("t4_stall%0d", c), mem_resp_ready, 0);
      if (ib_resp_valid) ib_seen = 1;
      if (db_resp_valid && db_resp_ready) begin
        chk($sformatf("t4_beat%0d", beats), db_resp_rdata, 64'hA000 + 64'(beats));
        beats++;
      end
      step();
      mem_resp_rdata = 64'hA000 + 64'(beats);
    end
    db_resp_ready = 1'b1;
    chk("t4_beats", beats, 8);
    chk("t4_ib_quiet", ib_seen, 0);
    @(negedge clk);
    chk("t4_no_extra", db_resp_valid, 0);

    // db write of max size still completes in one beat
    step();
    mem_resp_valid = 1'b0; mem_req_ready = 1'b0;
    db_req_valid = 1'b1; db_req_wen = 1'b1; db_req_wmask = 8'h0F;
    db_req_wdata = 64'hDEAD_BEEF; db_req_addr = 32'h3000; db_req_size = 3'd7;
    @(negedge clk);
    chk("t5_db_ready", db_req_ready, 1);
    step();
    db_req_valid = 1'b0;
    @(negedge clk);
    chk("t5_fields", {mem_req_valid, mem_req_wen, mem_req_wmask, mem_req_wdata, mem_req_addr},
        {1'b1, 1'b1, 8'h0F, 64'hDEAD_BEEF, 32'h3000});
    step();
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk("t5_held", mem_req_valid, 1);
    step();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1;
    @(negedge clk);
    chk("t5_resp", db_resp_valid, 1);
    step();
    mem_resp_valid = 1'b0; db_req_valid = 1'b1; db_req_wen = 1'b0; db_req_size = 3'd3;
    @(negedge clk);
    chk("t5_regrant", db_req_ready, 1);

    // reset in the middle of a response burst
    step();
    rst = 1'b1; idle_inputs(); step();
    rst = 1'b0;
    ib_req_valid = 1'b1; ib_req_size = 3'd7; ib_req_addr = 32'h4000; mem_req_ready = 1'b1;
    step();
    ib_req_valid = 1'b0;
    step();
    mem_resp_valid = 1'b1; mem_resp_rdata = 64'h55;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_all_zero", dut_out, '0);
    step();
    mem_resp_valid = 1'b0;
    ib_req_valid = 1'b1; ib_req_size = 3'd3; ib_req_addr = 32'h5000;
    step();
    ib_req_valid = 1'b0;
    @(negedge clk);
    chk("t6_addr", mem_req_addr, 32'h5000);
    step();
    mem_resp_valid = 1'b1; mem_resp_rdata = 64'hCAFE;
    @(negedge clk);
    chk("t6_resp", {ib_resp_valid, ib_resp_rdata}, {1'b1, 64'hCAFE});
    step();

    // randomized traffic, checked every cycle by the model
    for (int c = 0; c < 3000; c++) begin
      rst            = ($urandom_range(0, 299) == 0);
      ib_req_valid   = ($urandom_range(0, 2) == 0);
      ib_req_addr    = $urandom;
      ib_req_size    = 3'($urandom_range(0, 7));
      ib_resp_ready  = ($urandom_range(0, 3) != 0);
      db_req_valid   = ($urandom_range(0, 2) == 0);
      db_req_addr    = $urandom;
      db_req_wdata   = {$urandom, $urandom};
      db_req_wmask   = 8'($urandom);
      db_req_wen     = 1'($urandom);
      db_req_size    = 3'($urandom_range(0, 7));
      db_resp_ready  = ($urandom_range(0, 3) != 0);
      mem_req_ready  = 1'($urandom);
      mem_resp_valid = ($urandom_range(0, 9) < 7);
      mem_resp_rdata = {$urandom, $urandom};
      step();
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
